mic_fifo_ctrl: RTL and testbench

- Pointer, occupancy and handshake controller for the dual-port mic sample FIFO RAM (synchronous write, registered 1-cycle read).
- Accepts PCM samples from the microphone deserializer (valid-only, no backpressure) and presents them to the visualizer/FFT front end as a valid/ready stream.
- Drives the RAM's we/wr_addr/rd_addr/wr_data and consumes its rd_data.
- Handles the RAM read latency, overflow accounting and flush.

---
 rtl/mic_fifo_ctrl.sv | 143 ++++++++++++++
 tb/tb_mic_fifo_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mic_fifo_ctrl.sv
// Pointer/occupancy/handshake controller for the mic sample FIFO RAM (sync write, 1-cycle read).
// Optional MIC_FIFO_LEVEL_EN adds registered level and almost_full outputs.
module mic_fifo_ctrl #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 18,
    parameter int AF_MARGIN  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] sample_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  flush,
    input  logic                  ovf_clr,
    output logic                  overflow,
    output logic [15:0]           drop_cnt,
    output logic                  empty,
    output logic                  full,
`ifdef MIC_FIFO_LEVEL_EN
    output logic [ADDR_WIDTH:0]   level,
    output logic                  almost_full,
`endif
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH + 1)'(1);

    if (AF_MARGIN > DEPTH) begin : g_bad_margin
        $error("AF_MARGIN larger than FIFO depth");
    end

    typedef enum logic [1:0] {R_EMPTY, R_PRIME, R_VALID} rd_state_e;

    rd_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;
    logic                  push, pop, drop;

    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == '0);
    assign out_valid = (state_q == R_VALID);
    assign push      = sample_valid & ~full & ~flush;
    assign pop       = out_valid & out_ready & ~flush;
    assign drop      = sample_valid & full & ~flush;

    assign ram_we      = push & rst_n;
    assign ram_wr_addr = wr_ptr_q;
    assign ram_wr_data = sample_data;
    // Look-ahead read address so the next head is on ram_rd_data right after a pop.
    assign ram_rd_addr = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    assign out_data    = ram_rd_data;
    assign overflow    = overflow_q;
    assign drop_cnt    = drop_cnt_q;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            state_d  = R_EMPTY;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            case (state_q)
                R_EMPTY: if (count_q != '0) state_d = R_PRIME;
                R_PRIME: state_d = R_VALID;
                // An entry written this very cycle cannot be read yet: re-prime.
                R_VALID: if (pop && count_q == CNT_ONE) state_d = push ? R_PRIME : R_EMPTY;
                default: state_d = R_EMPTY;
            endcase
        end
    end

    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (ovf_clr) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (ovf_clr)                      drop_cnt_d = 16'd1;
            else if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= R_EMPTY;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

`ifdef MIC_FIFO_LEVEL_EN
    localparam logic [ADDR_WIDTH:0] AF_LEVEL = DEPTH_C - (ADDR_WIDTH + 1)'(AF_MARGIN);
    logic [ADDR_WIDTH:0] level_q;
    logic                almost_full_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q       <= '0;
            almost_full_q <= 1'b0;
        end else begin
            level_q       <= count_d;
            almost_full_q <= (count_d >= AF_LEVEL);
        end
    end

    assign level       = level_q;
    assign almost_full = almost_full_q;
`endif
endmodule

// File: tb/tb_mic_fifo_ctrl.sv
// Self-checking bench for mic_fifo_ctrl with a behavioural RAM and a queue-based FIFO model.
module tb_mic_fifo_ctrl;
  localparam int AW = 6;
  localparam int DW = 18;
  localparam int DEPTH = 64;
  localparam int AFM = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] sample_data = '0;
  logic          out_ready = 1'b0;
  logic          flush = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          out_valid, overflow, empty, full, ram_we;
  logic [DW-1:0] out_data, ram_wr_data;
  logic [DW-1:0] ram_rd_data = '0;
  logic [15:0]   drop_cnt;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;
`ifdef MIC_FIFO_LEVEL_EN
  logic [AW:0]   level;
  logic          almost_full;
`endif

  mic_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AF_MARGIN(AFM)) dut (
    .clk(clk), .rst_n(rst_n),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .ovf_clr(ovf_clr),
    .overflow(overflow), .drop_cnt(drop_cnt),
    .empty(empty), .full(full),
`ifdef MIC_FIFO_LEVEL_EN
    .level(level), .almost_full(almost_full),
`endif
    .ram_we(ram_we), .ram_wr_addr(ram_wr_addr), .ram_rd_addr(ram_rd_addr),
    .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Dual-port RAM: synchronous write, registered read, read-during-write gives old data
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) mem[ram_wr_addr] <= ram_wr_data;
    ram_rd_data <= mem[ram_rd_addr];
  end

  // Scoreboard / reference model
  // Handshake: out_valid marks out_data as head; the head leaves on a cycle with
  // out_valid & out_ready & !flush. Samples enter on sample_valid when not full.
  logic [DW-1:0] exp_q[$];
  bit  m_valid;
  int  m_pend;
  bit  m_ovf;
  int  m_drop;
  bit  m_full, m_push, m_pop, m_drop_now, m_was_empty;
  int  total = 0;
  int  bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_valid = 0; m_pend = 0; m_ovf = 0; m_drop = 0;
    end else begin
      m_full     = (exp_q.size() == DEPTH);
      m_push     = sample_valid && !m_full && !flush;
      m_pop      = m_valid && out_ready && !flush;
      m_drop_now = sample_valid && m_full && !flush;
      if (flush) begin
        exp_q.delete();
        m_valid = 0; m_pend = 0;
      end else begin
        m_was_empty = (exp_q.size() == 0);
        if (m_pop) void'(exp_q.pop_front());
        if (m_pend > 0) begin
          m_pend--;
          if (m_pend == 0) m_valid = 1;
        end
        if (m_pop) begin
          // remaining entries are older than this edge and readable at once
          if (exp_q.size() > 0) m_valid = 1;
          else if (m_push) begin m_valid = 0; m_pend = 1; end
          else m_valid = 0;
        end else if (m_push && m_was_empty) begin
          m_pend = 2;
        end
        if (m_push) exp_q.push_back(sample_data);
      end
      if (m_drop_now) begin
        m_ovf = 1;
        m_drop = ovf_clr ? 1 : ((m_drop == 65535) ? 65535 : m_drop + 1);
      end else if (ovf_clr) begin
        m_ovf = 0; m_drop = 0;
      end
    end
  end

  // Compare process, sampled away from the active edge
  always @(negedge clk) begin
    check("ram_we", 32'(ram_we),
          32'(rst_n && sample_valid && !flush && exp_q.size() < DEPTH));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("empty", 32'(empty), 32'(exp_q.size() == 0));
    check("full", 32'(full), 32'(exp_q.size() == DEPTH));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    if (rst_n && m_valid && exp_q.size() > 0) check("out_data", 32'(out_data), 32'(exp_q[0]));
    if (ram_we) check("ram_wr_data", 32'(ram_wr_data), 32'(sample_data));
`ifdef MIC_FIFO_LEVEL_EN
    check("level", 32'(level), 32'(exp_q.size()));
    check("almost_full", 32'(almost_full), 32'(exp_q.size() >= DEPTH - AFM));
`endif
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin
      sample_valid = 1'b1;
      sample_data = DW'($urandom);
      tick();
    end
    sample_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    sample_valid = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (!(empty && !out_valid) && guard < 200) begin
      tick();
      guard++;
    end
    check("drain_done", 32'(empty && !out_valid), 32'd1);
    out_ready = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    sample_valid = 1'b1;
    sample_data = 18'h15555;
    repeat (3) tick();
    rst_n = 1'b1;
    sample_valid = 1'b0;
    tick();

    // First-word latency
    sample_valid = 1'b1;
    sample_data = 18'h2A5A3;
    tick();
    sample_valid = 1'b0;
    check("lat_edge0", 32'(out_valid), 32'd0);
    tick();
    check("lat_edge1", 32'(out_valid), 32'd0);
    tick();
    check("lat_edge2_valid", 32'(out_valid), 32'd1);
    check("lat_edge2_data", 32'(out_data), 32'h2A5A3);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("lat_pop_empty", 32'(empty), 32'd1);
    check("lat_pop_valid", 32'(out_valid), 32'd0);
    do_flush();

    // Fill, overflow, drain with wrap
    push_n(64);
    check("fill_full", 32'(full), 32'd1);
    push_n(3);
    check("fill_overflow", 32'(overflow), 32'd1);
    check("fill_drop_cnt", 32'(drop_cnt), 32'd3);
    drain();
    check("wrap_rd_addr", 32'(ram_rd_addr), 32'd0);

    // Flush with count=20 and a concurrent sample
    sample_valid = 1'b1;
    sample_data = DW'($urandom);
    #1;
    check("wrap_wr_addr", 32'(ram_wr_addr), 32'd0);
    tick();
    push_n(19);
    flush = 1'b1;
    sample_valid = 1'b1;
    #1;
    check("flush_we", 32'(ram_we), 32'd0);
    tick();
    flush = 1'b0;
    sample_valid = 1'b0;
    check("flush_empty", 32'(empty), 32'd1);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_ovf_kept", 32'(overflow), 32'd1);
    check("flush_drop_kept", 32'(drop_cnt), 32'd3);
    sample_valid = 1'b1;
    sample_data = 18'h0BEEF;
    #1;
    check("flush_wr_addr", 32'(ram_wr_addr), 32'd0);
    tick();
    sample_valid = 1'b0;
    tick();
    tick();
    check("flush_readback", 32'(out_data), 32'h0BEEF);
    drain();

    // Steady stream, push every cycle with consumer always ready
    out_ready = 1'b1;
    push_n(200);
    check("stream_no_drop", 32'(drop_cnt), 32'd3);
    drain();

    // Random traffic with stalls, occasional clear and flush
    for (int i = 0; i < 1500; i++) begin
      sample_valid = ($urandom_range(0, 99) < 55);
      sample_data = DW'($urandom);
      out_ready = ($urandom_range(0, 1) == 1);
      ovf_clr = ($urandom_range(0, 63) == 0);
      flush = ($urandom_range(0, 99) == 0);
      if (flush && exp_q.size() == DEPTH) sample_valid = 1'b0;
      tick();
    end
    ovf_clr = 1'b0;
    flush = 1'b0;
    drain();

`ifdef MIC_FIFO_LEVEL_EN
    do_flush();
    push_n(56);
    check("lvl_56", 32'(level), 32'd56);
    check("af_56", 32'(almost_full), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("lvl_55", 32'(level), 32'd55);
    check("af_55", 32'(almost_full), 32'd0);
    drain();
`endif

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
